// File: rtl/itch_order_parser.sv
// Byte-serial ITCH 5.0 parser: decodes length-prefixed Add/Cancel/Delete messages into truncated field buses.
// Optional macro PARSER_EXEC_EN also decodes Order Executed ('E') messages as op 011 on the cancel bus.
module itch_order_parser #(
  parameter int PRICE_WIDTH = 15,
  parameter int ID_WIDTH    = 15,
  parameter int QUANT_WIDTH = 7,
  parameter int STOCK_WIDTH = 7
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [7:0]             data_in,
  input  logic                   enable_in,
  input  logic                   valid_microblaze_in,
  output logic                   ready_to_microblaze_out,
  output logic [2:0]             operation_out,
  output logic [STOCK_WIDTH:0]   stock_symbol_out_add,
  output logic [ID_WIDTH:0]      order_id_out_add,
  output logic [PRICE_WIDTH:0]   price_out_add,
  output logic [QUANT_WIDTH:0]   quantity_out_add,
  output logic [STOCK_WIDTH:0]   stock_symbol_out_cancel,
  output logic [ID_WIDTH:0]      order_id_out_cancel,
  output logic [PRICE_WIDTH:0]   price_out_cancel,
  output logic [QUANT_WIDTH:0]   quantity_out_cancel,
  output logic                   delete_out,
  input  logic                   valid_master_in,
  output logic                   last_master_out,
  output logic                   ready_out
);

  localparam int PRICE_W = PRICE_WIDTH + 1;
  localparam int ID_W    = ID_WIDTH + 1;
  localparam int QUANT_W = QUANT_WIDTH + 1;
  localparam int STOCK_W = STOCK_WIDTH + 1;

  localparam logic [2:0] OP_DELETE = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_CANCEL = 3'b010;
`ifdef PARSER_EXEC_EN
  localparam logic [2:0] OP_EXEC   = 3'b011;
`endif
  localparam logic [2:0] OP_NONE   = 3'b111;

  typedef enum logic [2:0] {LEN_HI, LEN_LO, TYPE, BODY, SKIP, OUT} state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           op_pend_q, op_pend_d;
  logic [2:0]           op_q, op_d;
  logic [ID_WIDTH:0]    id_sh_q, id_sh_d;
  logic [QUANT_WIDTH:0] qty_sh_q, qty_sh_d;
  logic [STOCK_WIDTH:0] stock_sh_q, stock_sh_d;
  logic [PRICE_WIDTH:0] price_sh_q, price_sh_d;
  logic [STOCK_WIDTH:0] stock_add_q, stock_add_d;
  logic [ID_WIDTH:0]    id_add_q, id_add_d;
  logic [PRICE_WIDTH:0] price_add_q, price_add_d;
  logic [QUANT_WIDTH:0] qty_add_q, qty_add_d;
  logic [ID_WIDTH:0]    id_cxl_q, id_cxl_d;
  logic [QUANT_WIDTH:0] qty_cxl_q, qty_cxl_d;

  logic accept;
  logic last_byte;
  logic qty_window;

  assign ready_out               = (state_q == OUT);
  assign last_master_out         = ready_out;
  assign ready_to_microblaze_out = ~ready_out;
  assign delete_out              = ready_out && (op_q == OP_DELETE);
  assign operation_out           = op_q;
  assign stock_symbol_out_add    = stock_add_q;
  assign order_id_out_add        = id_add_q;
  assign price_out_add           = price_add_q;
  assign quantity_out_add        = qty_add_q;
  assign stock_symbol_out_cancel = '0;
  assign order_id_out_cancel     = id_cxl_q;
  assign price_out_cancel        = '0;
  assign quantity_out_cancel     = qty_cxl_q;

  assign accept    = enable_in && valid_microblaze_in && ready_to_microblaze_out;
  assign last_byte = (cnt_q == len_q - 16'd1);

  // Add carries shares at 20-23; cancel and execute carry them at 19-22.
  assign qty_window = (op_pend_q == OP_ADD) ? (cnt_q >= 16'd20 && cnt_q <= 16'd23)
                                            : (cnt_q >= 16'd19 && cnt_q <= 16'd22);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    op_pend_d   = op_pend_q;
    op_d        = op_q;
    id_sh_d     = id_sh_q;
    qty_sh_d    = qty_sh_q;
    stock_sh_d  = stock_sh_q;
    price_sh_d  = price_sh_q;
    stock_add_d = stock_add_q;
    id_add_d    = id_add_q;
    price_add_d = price_add_q;
    qty_add_d   = qty_add_q;
    id_cxl_d    = id_cxl_q;
    qty_cxl_d   = qty_cxl_q;

    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = data_in;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = data_in;
          cnt_d      = 16'd0;
          state_d    = ({len_q[15:8], data_in} == 16'd0) ? LEN_HI : TYPE;
        end
      end
      TYPE: begin
        if (accept) begin
          cnt_d      = 16'd1;
          id_sh_d    = '0;
          qty_sh_d   = '0;
          stock_sh_d = '0;
          price_sh_d = '0;
          if (data_in == 8'h41 && len_q >= 16'd36) begin
            op_pend_d = OP_ADD;
            state_d   = BODY;
          end else if (data_in == 8'h58 && len_q >= 16'd23) begin
            op_pend_d = OP_CANCEL;
            state_d   = BODY;
          end else if (data_in == 8'h44 && len_q >= 16'd19) begin
            op_pend_d = OP_DELETE;
            state_d   = BODY;
`ifdef PARSER_EXEC_EN
          end else if (data_in == 8'h45 && len_q >= 16'd31) begin
            op_pend_d = OP_EXEC;
            state_d   = BODY;
`endif
          end else begin
            state_d = (len_q == 16'd1) ? LEN_HI : SKIP;
          end
        end
      end
      BODY: begin
        if (accept) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q >= 16'd11 && cnt_q <= 16'd18)
            id_sh_d = ID_W'({id_sh_q, data_in});
          if (qty_window)
            qty_sh_d = QUANT_W'({qty_sh_q, data_in});
          if (op_pend_q == OP_ADD && cnt_q == 16'd24)
            stock_sh_d = STOCK_W'(data_in);
          if (op_pend_q == OP_ADD && cnt_q >= 16'd32 && cnt_q <= 16'd35)
            price_sh_d = PRICE_W'({price_sh_q, data_in});
          // Result buses load from the shift registers including the byte being accepted now.
          if (last_byte) begin
            state_d = OUT;
            op_d    = op_pend_q;
            if (op_pend_q == OP_ADD) begin
              stock_add_d = stock_sh_d;
              id_add_d    = id_sh_d;
              price_add_d = price_sh_d;
              qty_add_d   = qty_sh_d;
            end else begin
              id_cxl_d  = id_sh_d;
              qty_cxl_d = (op_pend_q == OP_DELETE) ? '0 : qty_sh_d;
            end
          end
        end
      end
      SKIP: begin
        if (accept) begin
          cnt_d = cnt_q + 16'd1;
          if (last_byte)
            state_d = LEN_HI;
        end
      end
      OUT: begin
        if (enable_in && valid_master_in)
          state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      cnt_q       <= '0;
      op_pend_q   <= OP_NONE;
      op_q        <= OP_NONE;
      id_sh_q     <= '0;
      qty_sh_q    <= '0;
      stock_sh_q  <= '0;
      price_sh_q  <= '0;
      stock_add_q <= '0;
      id_add_q    <= '0;
      price_add_q <= '0;
      qty_add_q   <= '0;
      id_cxl_q    <= '0;
      qty_cxl_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      op_pend_q   <= op_pend_d;
      op_q        <= op_d;
      id_sh_q     <= id_sh_d;
      qty_sh_q    <= qty_sh_d;
      stock_sh_q  <= stock_sh_d;
      price_sh_q  <= price_sh_d;
      stock_add_q <= stock_add_d;
      id_add_q    <= id_add_d;
      price_add_q <= price_add_d;
      qty_add_q   <= qty_add_d;
      id_cxl_q    <= id_cxl_d;
      qty_cxl_q   <= qty_cxl_d;
    end
  end

endmodule

// File: tb/tb_itch_order_parser.sv
// Directed self-checking bench for itch_order_parser: hand-built ITCH messages with hand-computed field values.
module tb_itch_order_parser;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [7:0]  data_in;
  logic        enable_in;
  logic        valid_microblaze_in;
  logic        ready_to_microblaze_out;
  logic [2:0]  operation_out;
  logic [7:0]  stock_symbol_out_add;
  logic [15:0] order_id_out_add;
  logic [15:0] price_out_add;
  logic [7:0]  quantity_out_add;
  logic [7:0]  stock_symbol_out_cancel;
  logic [15:0] order_id_out_cancel;
  logic [15:0] price_out_cancel;
  logic [7:0]  quantity_out_cancel;
  logic        delete_out;
  logic        valid_master_in;
  logic        last_master_out;
  logic        ready_out;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [7:0] body[$];

  itch_order_parser dut (
    .clk_in                  (clk_in),
    .reset_in                (reset_in),
    .data_in                 (data_in),
    .enable_in               (enable_in),
    .valid_microblaze_in     (valid_microblaze_in),
    .ready_to_microblaze_out (ready_to_microblaze_out),
    .operation_out           (operation_out),
    .stock_symbol_out_add    (stock_symbol_out_add),
    .order_id_out_add        (order_id_out_add),
    .price_out_add           (price_out_add),
    .quantity_out_add        (quantity_out_add),
    .stock_symbol_out_cancel (stock_symbol_out_cancel),
    .order_id_out_cancel     (order_id_out_cancel),
    .price_out_cancel        (price_out_cancel),
    .quantity_out_cancel     (quantity_out_cancel),
    .delete_out              (delete_out),
    .valid_master_in         (valid_master_in),
    .last_master_out         (last_master_out),
    .ready_out               (ready_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge following the edge that accepted the byte.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    data_in = b;
    valid_microblaze_in = 1'b1;
    while (ready_to_microblaze_out !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) checkOutput("byte_accept_timeout", 32'(ready_to_microblaze_out), 32'h1);
    @(negedge clk_in);
    valid_microblaze_in = 1'b0;
  endtask

  // Stream index 0/1 are the length bytes, then message bytes from body (0xFF beyond its end).
  task automatic send_stream(input int len, input int from, input int upto);
    logic [15:0] l16;
    l16 = 16'(len);
    for (int s = from; s < upto; s++) begin
      if (s == 0) applyStimulus(l16[15:8]);
      else if (s == 1) applyStimulus(l16[7:0]);
      else applyStimulus((s - 2) < body.size() ? body[s - 2] : 8'hFF);
    end
  endtask

  task automatic send_msg(input int len);
    send_stream(len, 0, len + 2);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) body.push_back(8'h00);
  endtask

  task automatic build_add();
    body = {};
    body.push_back(8'h41);
    push_zeros(9);
    body.push_back(8'h0a);
    push_zeros(7);
    body.push_back(8'h01);
    body.push_back(8'h42);
    push_zeros(3);
    body.push_back(8'h01);
    body.push_back(8'h41); body.push_back(8'h41); body.push_back(8'h50); body.push_back(8'h4C);
    for (int i = 0; i < 4; i++) body.push_back(8'h20);
    body.push_back(8'h01); body.push_back(8'h86); body.push_back(8'ha0); body.push_back(8'h00);
  endtask

  // Type byte, ten zero bytes, 8-byte ref ending in ref_lo, 4-byte shares ending in shares_lo.
  task automatic build_ref_msg(input logic [7:0] typ, input logic [7:0] ref_lo, input logic [7:0] shares_lo, input bit with_shares);
    body = {};
    body.push_back(typ);
    push_zeros(10);
    push_zeros(7);
    body.push_back(ref_lo);
    if (with_shares) begin
      push_zeros(3);
      body.push_back(shares_lo);
    end
  endtask

  task automatic check_add(input string tag);
    checkOutput({tag, "_ready"}, 32'(ready_out), 32'h1);
    checkOutput({tag, "_last"}, 32'(last_master_out), 32'h1);
    checkOutput({tag, "_op"}, 32'(operation_out), 32'h1);
    checkOutput({tag, "_stock"}, 32'(stock_symbol_out_add), 32'h41);
    checkOutput({tag, "_id"}, 32'(order_id_out_add), 32'h0001);
    checkOutput({tag, "_price"}, 32'(price_out_add), 32'hA000);
    checkOutput({tag, "_qty"}, 32'(quantity_out_add), 32'h01);
    checkOutput({tag, "_delete"}, 32'(delete_out), 32'h0);
    checkOutput({tag, "_rtm"}, 32'(ready_to_microblaze_out), 32'h0);
  endtask

  initial begin
    reset_in = 1'b0;
    enable_in = 1'b1;
    valid_microblaze_in = 1'b0;
    valid_master_in = 1'b1;
    data_in = 8'h00;
    repeat (2) @(negedge clk_in);
    checkOutput("reset_ready", 32'(ready_out), 32'h0);
    checkOutput("reset_op", 32'(operation_out), 32'h7);
    checkOutput("reset_rtm", 32'(ready_to_microblaze_out), 32'h1);
    checkOutput("reset_delete", 32'(delete_out), 32'h0);
    checkOutput("reset_id_add", 32'(order_id_out_add), 32'h0);
    reset_in = 1'b1;
    @(negedge clk_in);

    build_add();
    send_msg(36);
    check_add("add");
    @(negedge clk_in);
    checkOutput("add_pulse_end", 32'(ready_out), 32'h0);

    build_ref_msg(8'h58, 8'h05, 8'h10, 1'b1);
    send_msg(23);
    checkOutput("cxl_ready", 32'(ready_out), 32'h1);
    checkOutput("cxl_op", 32'(operation_out), 32'h2);
    checkOutput("cxl_id", 32'(order_id_out_cancel), 32'h0005);
    checkOutput("cxl_qty", 32'(quantity_out_cancel), 32'h10);
    checkOutput("cxl_price", 32'(price_out_cancel), 32'h0);
    checkOutput("cxl_stock", 32'(stock_symbol_out_cancel), 32'h0);
    checkOutput("cxl_add_kept", 32'(order_id_out_add), 32'h0001);

    build_ref_msg(8'h44, 8'h07, 8'h00, 1'b0);
    send_msg(19);
    checkOutput("del_op", 32'(operation_out), 32'h0);
    checkOutput("del_flag", 32'(delete_out), 32'h1);
    checkOutput("del_id", 32'(order_id_out_cancel), 32'h0007);
    checkOutput("del_qty", 32'(quantity_out_cancel), 32'h0);
    @(negedge clk_in);
    checkOutput("del_flag_end", 32'(delete_out), 32'h0);

    body = {};
    body.push_back(8'h53);
    push_zeros(11);
    send_msg(12);
    checkOutput("unknown_no_ready", 32'(ready_out), 32'h0);
    build_add();
    send_msg(36);
    check_add("after_unknown");

    build_ref_msg(8'h45, 8'h09, 8'h20, 1'b1);
    push_zeros(8);
    send_msg(31);
`ifdef PARSER_EXEC_EN
    checkOutput("exec_op", 32'(operation_out), 32'h3);
    checkOutput("exec_id", 32'(order_id_out_cancel), 32'h0009);
    checkOutput("exec_qty", 32'(quantity_out_cancel), 32'h20);
`else
    checkOutput("exec_skipped", 32'(ready_out), 32'h0);
`endif

    build_add();
    send_msg(35);
    checkOutput("short_add_skipped", 32'(ready_out), 32'h0);

    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("len0_no_ready", 32'(ready_out), 32'h0);
    send_msg(37);
    check_add("trailing_add");

    send_stream(36, 0, 12);
    enable_in = 1'b0;
    valid_microblaze_in = 1'b1;
    valid_master_in = 1'b1;
    data_in = 8'hEE;
    repeat (4) @(negedge clk_in);
    checkOutput("freeze_ready", 32'(ready_out), 32'h0);
    checkOutput("freeze_rtm", 32'(ready_to_microblaze_out), 32'h1);
    enable_in = 1'b1;
    valid_microblaze_in = 1'b0;
    send_stream(36, 12, 38);
    check_add("freeze_add");

    send_stream(36, 0, 10);
    reset_in = 1'b0;
    @(negedge clk_in);
    checkOutput("midreset_ready", 32'(ready_out), 32'h0);
    checkOutput("midreset_op", 32'(operation_out), 32'h7);
    checkOutput("midreset_id_add", 32'(order_id_out_add), 32'h0);
    reset_in = 1'b1;
    send_msg(36);
    check_add("post_reset_add");

    @(negedge clk_in);
    valid_master_in = 1'b0;
    send_msg(36);
    valid_microblaze_in = 1'b1;
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_ready", 32'(ready_out), 32'h1);
      checkOutput("bp_rtm", 32'(ready_to_microblaze_out), 32'h0);
      checkOutput("bp_price", 32'(price_out_add), 32'hA000);
      @(negedge clk_in);
    end
    valid_master_in = 1'b1;
    @(negedge clk_in);
    valid_microblaze_in = 1'b0;
    checkOutput("bp_release", 32'(ready_out), 32'h0);
    build_ref_msg(8'h58, 8'h05, 8'h10, 1'b1);
    send_msg(23);
    checkOutput("bp_next_op", 32'(operation_out), 32'h2);
    checkOutput("bp_next_qty", 32'(quantity_out_cancel), 32'h10);

    @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
